// File: rtl/bf16_add_simd_pipe.sv
// rtl/bf16_add_simd_pipe.sv - LANES-wide bf16 add/sub with per-lane IEEE flags behind an elastic STAGES-deep pipeline.
// Arithmetic is combinational ahead of stage 0; the stages only carry registered results.
module bf16_add_simd_pipe #(
   parameter int LANES  = 2,
   parameter int STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  op_sub,
   input  logic [LANES-1:0]      lane_en,
   input  logic [16*LANES-1:0]   X,
   input  logic [16*LANES-1:0]   Y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*LANES-1:0]   R,
   output logic [4*LANES-1:0]    flags
);

   localparam int W  = 16 * LANES;
   localparam int FW = 4 * LANES;

   // Returns {nv, of, uf, nx, result[15:0]} for one lane.
   function automatic logic [19:0] f_lane(input logic [15:0] a, input logic [15:0] b, input logic sub);
      logic              sa, sb, a_nan, b_nan, a_inf, b_inf, swap, s_big, eff_sub;
      logic              sticky, g, rest, rnd, found;
      logic [7:0]        ea, eb, ma, mb, e_big, e_small, m_big, m_small, d;
      logic [10:0]       ext, shifted, m;
      logic [11:0]       sum;
      logic [3:0]        lz, sh;
      logic signed [9:0] e;
      logic [8:0]        mr;
      logic [15:0]       r;
      logic [3:0]        fl;

      sa    = a[15];
      sb    = b[15] ^ sub;
      ea    = a[14:7];
      eb    = b[14:7];
      a_nan = (ea == 8'hFF) && (a[6:0] != 7'd0);
      b_nan = (eb == 8'hFF) && (b[6:0] != 7'd0);
      a_inf = (ea == 8'hFF) && (a[6:0] == 7'd0);
      b_inf = (eb == 8'hFF) && (b[6:0] == 7'd0);
      ma    = (ea == 8'd0) ? 8'd0 : {1'b1, a[6:0]};
      mb    = (eb == 8'd0) ? 8'd0 : {1'b1, b[6:0]};

      // Order by magnitude so the subtract never goes negative.
      swap    = {eb, mb} > {ea, ma};
      s_big   = swap ? sb : sa;
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      m_big   = swap ? mb : ma;
      m_small = swap ? ma : mb;
      eff_sub = sa ^ sb;

      d   = e_big - e_small;
      sh  = d[3:0];
      ext = {m_small, 3'b000};
      if (d > 8'd10) begin
         shifted = 11'd0;
         sticky  = |m_small;
      end else begin
         shifted = ext >> sh;
         sticky  = |(ext << (4'd11 - sh));
      end
      shifted[0] = shifted[0] | sticky;

      if (eff_sub)
         sum = {1'b0, m_big, 3'b000} - {1'b0, shifted};
      else
         sum = {1'b0, m_big, 3'b000} + {1'b0, shifted};

      lz    = 4'd0;
      found = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lz    = 4'(10 - i);
            found = 1'b1;
         end
      end

      if (sum[11]) begin
         m = {sum[11:2], sum[1] | sum[0]};
         e = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         m = sum[10:0] << lz;
         e = $signed({2'b00, e_big}) - $signed({6'd0, lz});
      end

      g    = m[2];
      rest = m[1] | m[0];
      rnd  = g & (rest | m[3]);
      mr   = {1'b0, m[10:3]} + {8'd0, rnd};
      if (mr[8])
         e = e + 10'sd1;

      r  = 16'd0;
      fl = 4'd0;
      if (a_nan || b_nan) begin
         r     = 16'h7FC0;
         fl[3] = (a_nan & ~a[6]) | (b_nan & ~b[6]);
      end else if (a_inf && b_inf) begin
         if (eff_sub) begin
            r     = 16'h7FC0;
            fl[3] = 1'b1;
         end else begin
            r = {sa, 8'hFF, 7'd0};
         end
      end else if (a_inf) begin
         r = {sa, 8'hFF, 7'd0};
      end else if (b_inf) begin
         r = {sb, 8'hFF, 7'd0};
      end else if (sum == 12'd0) begin
         // Only two signed zeros keep their sign; any cancellation is +0.
         r = {(m_big == 8'd0) & sa & sb, 15'd0};
      end else if (e >= 10'sd255) begin
         r  = {s_big, 8'hFF, 7'd0};
         fl = 4'b0101;
      end else if (e <= 10'sd0) begin
         r  = {s_big, 15'd0};
         fl = 4'b0011;
      end else begin
         r     = {s_big, e[7:0], mr[8] ? 7'd0 : mr[6:0]};
         fl[0] = g | rest;
      end
      return {fl, r};
   endfunction

   logic [W-1:0]                w_res;
   logic [FW-1:0]               w_flg;
   logic [19:0]                 w_lane;
   logic [STAGES-1:0]           w_adv;
   logic [STAGES-1:0]           w_src_valid;
   logic [STAGES-1:0][W-1:0]    w_src_res;
   logic [STAGES-1:0][FW-1:0]   w_src_flg;
   logic                        w_hole;

   logic [STAGES-1:0]           r_valid;
   logic [STAGES-1:0][W-1:0]    r_res;
   logic [STAGES-1:0][FW-1:0]   r_flg;

   always_comb begin
      w_res  = '0;
      w_flg  = '0;
      w_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         w_lane = f_lane(X[16*i +: 16], Y[16*i +: 16], op_sub);
         if (lane_en[i]) begin
            w_res[16*i +: 16] = w_lane[15:0];
            w_flg[4*i +: 4]   = w_lane[19:16];
         end else begin
            w_res[16*i +: 16] = X[16*i +: 16];
         end
      end
   end

   // A stage moves on when any later stage is empty or the output is being consumed.
   always_comb begin
      w_adv  = '0;
      w_hole = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         w_hole = 1'b0;
         for (int j = k + 1; j < STAGES; j++)
            w_hole = w_hole | ~r_valid[j];
         w_adv[k] = r_valid[k] & (w_hole | out_ready);
      end
   end

   always_comb begin
      w_src_valid    = '0;
      w_src_res      = '0;
      w_src_flg      = '0;
      w_src_valid[0] = in_valid;
      w_src_res[0]   = w_res;
      w_src_flg[0]   = w_flg;
      for (int k = 1; k < STAGES; k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_res[k]   = r_res[k-1];
         w_src_flg[k]   = r_flg[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_res   <= '0;
         r_flg   <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (!r_valid[k] || w_adv[k]) begin
               r_valid[k] <= w_src_valid[k];
               if (w_src_valid[k]) begin
                  r_res[k] <= w_src_res[k];
                  r_flg[k] <= w_src_flg[k];
               end
            end
         end
      end
   end

   assign in_ready  = ~r_valid[0] | w_adv[0];
   assign out_valid = r_valid[STAGES-1];
   assign R         = r_res[STAGES-1];
   assign flags     = r_flg[STAGES-1];

endmodule

// File: doc/bf16_add_simd_pipe.md
Name: bf16_add_simd_pipe

Overview:
- Parametrised successor to the fixed bf16x2 add datapath: LANES independent bf16 adders sharing one valid/ready pipeline of STAGES register stages.
- Adds ADD/SUB selection, a per-lane enable mask, per-lane IEEE exception flags, and backpressure.
- Sits between the FPALL operand-issue logic and the result writeback; one operation vector per accepted beat.

Parameters:
LANES, 2, number of 16-bit bf16 lanes (1..8); lane i occupies bits [16i+15:16i]
STAGES, 2, pipeline register stages between input acceptance and output (1..4); equals latency in cycles

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
op_sub  input  1  0: R=X+Y, 1: R=X-Y (Y sign inverted before add)
lane_en  input  LANES  per-lane enable; disabled lane outputs X unchanged, flags 0
X  input  16*LANES  operand A, packed bf16
Y  input  16*LANES  operand B, packed bf16
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
R  output  16*LANES  packed bf16 results
flags  output  4*LANES  per lane {nv,of,uf,nx} at bits [4i+3:4i]

Behaviour:
- Reset (async assert, held while rst=1): all stage valid bits 0, out_valid=0, R=0, flags=0; in_ready=1 from the first cycle after deassertion. Reset mid-operation discards all in-flight beats.
- Handshake: beat accepted when in_valid&in_ready; result consumed when out_valid&out_ready. Inputs are sampled only on acceptance.
- Elastic shift pipeline: stage k loads from stage k-1 when stage k is empty or stage k is advancing. in_ready = ~valid[0] | advance[0]; out_valid = valid[STAGES-1]. No bubbles when out_ready=1: throughput 1 beat/cycle, latency exactly STAGES cycles from acceptance to out_valid.
- Stall (out_ready=0): R/flags/out_valid held stable; the pipeline fills, and in_ready drops once all STAGES entries are valid. Simultaneous consume and accept on a full pipeline is legal, and occupancy is unchanged.
- Arithmetic per enabled lane is combinational before stage 0; stages carry registered results only.
- Subnormal inputs (exp=0) are treated as signed zero (DAZ).
- Align: the smaller-exponent significand is shifted right with guard, round and sticky bits.
- Add/sub, then normalise: leading-zero shift or 1-bit right shift on carry-out.
- Round to nearest even on the 7-bit fraction; a rounding carry re-normalises.
- Exact zero result: +0, except (-0)+(-0) = -0.
- Result exponent >= 255 after rounding: ±inf (0x7F80/0xFF80), of=1, nx=1.
- Result below min normal: signed zero (FTZ), uf=1, nx=1.
- nx=1 whenever any discarded bit is nonzero.
- Either operand NaN, or inf + (-inf) after op_sub is applied: canonical NaN 0x7FC0. nv=1 for the inf-inf case or a signalling NaN input (frac[6]=0); a quiet NaN input gives nv=0.
- inf + finite: that inf, flags 0.
- Lanes are fully independent; no cross-lane carry or flag merging.

Test Plan:
- LANES=2, STAGES=2, X=0x3F803F80, Y=0x3F803F80, op_sub=0 -> after exactly 2 cycles R=0x40004000, flags=0.
- X=0x3FC03FC0, Y=0x3FA03FA0, op_sub=1 -> R=0x3E803E80 (0.25 each lane), flags=0. X=0x3F80, Y=0x3F80, op_sub=1 -> +0 (0x0000).
- Rounding ties: 0x3F80+0x3B80 -> 0x3F80 with nx=1; 0x3F81+0x3B80 -> 0x3F82 with nx=1.
- Specials per lane: 0x7F7F+0x7F7F -> 0x7F80 with of=1,nx=1; 0x7F80+0xFF80 -> 0x7FC0 with nv=1; 0x7FC1+0x3F80 -> 0x7FC0 with nv=0; 0x0001+0x8001 -> 0x0000.
- Backpressure, STAGES=3: stream 5 beats with out_ready=0 -> in_ready falls after 3 acceptances and R holds the first result. Then raise out_ready -> results emerge in order at 1/cycle with no loss or duplication. Toggle out_ready randomly over 2000 random normal vectors and compare against the shortreal reference with RNE.
- lane_en=2'b01 with X=0x40003F80, Y=0x3F803F80 -> R=0x40004000 (upper lane passes X), flags[7:4]=0. Assert rst with 2 beats in flight -> out_valid=0 immediately; after release no stale results appear.
